cv32e40p_apu_resp: RTL and testbench



---
 rtl/cv32e40p_apu_resp_pkg.sv | 49 ++++
 rtl/cv32e40p_apu_resp_div.sv | 88 ++++++++
 rtl/cv32e40p_apu_resp.sv | 162 ++++++++++++++++
 tb/tb_cv32e40p_apu_resp.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_apu_resp_pkg.sv
// Shared definitions for the APU responder: op codes, latency classes,
// divider states, result-flag positions and the pipeline entry layout.
package cv32e40p_apu_resp_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLTU  = 4'd5;
    localparam logic [3:0] OP_MUL   = 4'd6;
    localparam logic [3:0] OP_MULHU = 4'd7;
    localparam logic [3:0] OP_DIVU  = 4'd8;

    localparam int FLAG_ILLEGAL  = 0;
    localparam int FLAG_DIV_ZERO = 1;

    typedef enum logic [1:0] {
        LAT_1,
        LAT_PIPE,
        LAT_ITER
    } lat_class_e;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic [1:0]  flags;
    } pipe_entry_t;

    // Illegal ops (and DIVU with the divider compiled out) are answered
    // by the single-cycle path with the illegal flag set.
    function automatic lat_class_e op_class(input logic [3:0] op, input logic div_enable);
        lat_class_e cls;
        cls = LAT_1;
        if (op == OP_MUL || op == OP_MULHU) begin
            cls = LAT_PIPE;
        end else if (op == OP_DIVU && div_enable) begin
            cls = LAT_ITER;
        end
        return cls;
    endfunction

endpackage

// File: rtl/cv32e40p_apu_resp_div.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// IDLE -> BUSY (32 cycles) -> DONE (one cycle, result valid) -> IDLE.
module cv32e40p_apu_resp_div
    import cv32e40p_apu_resp_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_start,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_quotient,
    output logic        o_div_zero
);

    div_state_e  r_state;
    div_state_e  w_state_next;
    logic [4:0]  r_count;
    logic [31:0] r_quot;
    logic [31:0] r_rem;
    logic [31:0] r_divisor;
    logic        r_div_zero;

    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_fits;

    // One restoring step: shift the next dividend bit into the remainder
    // and subtract if the divisor fits (no borrow out of bit 32).
    always_comb begin
        w_shift = {r_rem, r_quot[31]};
        w_diff  = w_shift - {1'b0, r_divisor};
        w_fits  = ~w_diff[32];
    end

    // Next-state logic; a zero divisor still takes the full 32 steps and
    // naturally yields an all-ones quotient.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        w_state_next = r_state;
        case (r_state)
            DIV_IDLE: if (i_start) w_state_next = DIV_BUSY;
            DIV_BUSY: if (r_count == 5'd31) w_state_next = DIV_DONE;
            DIV_DONE: w_state_next = DIV_IDLE;
            default:  w_state_next = DIV_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= DIV_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            r_state <= w_state_next;
        end
    end

    // Datapath: latch operands on start, then one quotient bit per BUSY cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count    <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_divisor  <= '0;
            r_div_zero <= 1'b0;
        end else if (r_state == DIV_IDLE && i_start) begin
            r_count    <= '0;
            r_quot     <= i_dividend;
            r_rem      <= '0;
            r_divisor  <= i_divisor;
            r_div_zero <= (i_divisor == 32'd0);
        end else if (r_state == DIV_BUSY) begin
            r_count <= r_count + 5'd1;
            r_quot  <= {r_quot[30:0], w_fits};
            r_rem   <= w_fits ? w_diff[31:0] : w_shift[31:0];
        end
    end

    assign o_busy     = (r_state != DIV_IDLE);
    assign o_done     = (r_state == DIV_DONE);
    assign o_quotient = r_quot;
    assign o_div_zero = r_div_zero;

endmodule

// File: rtl/cv32e40p_apu_resp.sv
// APU responder: grants requests, computes single-cycle, pipelined and
// iterative ops, and returns one rvalid per grant in grant order.
module cv32e40p_apu_resp
    import cv32e40p_apu_resp_pkg::*;
#(
    parameter int PIPE_DEPTH = 3,
    parameter bit DIV_ENABLE = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             apu_req_i,
    output logic             apu_gnt_o,
    input  logic [3:0]       apu_op_i,
    input  logic [1:0][31:0] apu_operands_i,
    output logic             apu_rvalid_o,
    output logic [31:0]      apu_result_o,
    output logic [1:0]       apu_rflags_o,
    output logic             active_o
);

    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [63:0] w_prod;
    lat_class_e  w_class;
    logic        w_gnt;
    logic        w_pipe_busy;
    logic        w_any_valid;
    logic        w_div_busy;
    logic        w_div_done;
    logic [31:0] w_div_quot;
    logic        w_div_zero;
    logic [1:0]  w_div_flags;
    pipe_entry_t w_fast;
    pipe_entry_t w_slow;
    pipe_entry_t w_tail;
    pipe_entry_t w_pipe_next [PIPE_DEPTH];
    pipe_entry_t r_pipe      [PIPE_DEPTH];

    assign w_a     = apu_operands_i[0];
    assign w_b     = apu_operands_i[1];
    assign w_prod  = 64'(w_a) * 64'(w_b);
    assign w_class = op_class(apu_op_i, DIV_ENABLE);
    assign w_tail  = r_pipe[PIPE_DEPTH-1];

    // Class-2 ops still travelling toward the tail; the tail itself returns
    // this cycle, so its slot is free for a class-1 result.
    always_comb begin
        w_pipe_busy = 1'b0;
        w_any_valid = 1'b0;
        for (int k = 0; k < PIPE_DEPTH - 1; k++) begin
            w_pipe_busy = w_pipe_busy | r_pipe[k].valid;
        end
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            w_any_valid = w_any_valid | r_pipe[k].valid;
        end
    end

    // Grant: nothing while the divider is active; class 1 and 3 also wait
    // for in-flight multiplies so they cannot overtake or collide.
    always_comb begin
        w_gnt = 1'b0;
        if (apu_req_i && !rst_i && !w_div_busy) begin
            w_gnt = (w_class == LAT_PIPE) || !w_pipe_busy;
        end
    end

    assign apu_gnt_o = w_gnt;

    // Single-cycle results; anything not listed here is illegal.
    always_comb begin
        w_fast       = '0;
        w_fast.valid = 1'b1;
        case (apu_op_i)
            OP_ADD:  w_fast.result = w_a + w_b;
            OP_SUB:  w_fast.result = w_a - w_b;
            OP_AND:  w_fast.result = w_a & w_b;
            OP_OR:   w_fast.result = w_a | w_b;
            OP_XOR:  w_fast.result = w_a ^ w_b;
            OP_SLTU: w_fast.result = {31'd0, (w_a < w_b)};
            default: w_fast.flags[FLAG_ILLEGAL] = 1'b1;
        endcase
    end

    // Multiply result selection for the pipelined class.
    always_comb begin
        w_slow        = '0;
        w_slow.valid  = 1'b1;
        w_slow.result = (apu_op_i == OP_MULHU) ? w_prod[63:32] : w_prod[31:0];
    end

    // Pipeline shift: multiplies enter stage 0, single-cycle ops enter the tail.
    always_comb begin
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            w_pipe_next[k] = '0;
        end
        if (w_gnt && w_class == LAT_PIPE) begin
            w_pipe_next[0] = w_slow;
        end
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            w_pipe_next[k] = r_pipe[k-1];
        end
        if (w_gnt && w_class == LAT_1) begin
            w_pipe_next[PIPE_DEPTH-1] = w_fast;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the whole entry is cleared, not just the valid bit, so
            // in-flight results are dropped and stale data never reaches
            // the output after reset.
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                r_pipe[k] <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                r_pipe[k] <= w_pipe_next[k];
            end
        end
    end

    cv32e40p_apu_resp_div u_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_start    (w_gnt && w_class == LAT_ITER),
        .i_dividend (w_a),
        .i_divisor  (w_b),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_div_quot),
        .o_div_zero (w_div_zero)
    );

    // Divider flag vector built from the named bit positions.
    always_comb begin
        w_div_flags                = '0;
        w_div_flags[FLAG_DIV_ZERO] = w_div_zero;
    end

    // Output mux: pipeline tail or divider DONE; result/flags zero otherwise.
    always_comb begin
        apu_rvalid_o = w_tail.valid | w_div_done;
        apu_result_o = '0;
        apu_rflags_o = '0;
        if (w_tail.valid) begin
            apu_result_o = w_tail.result;
            apu_rflags_o = w_tail.flags;
        end else if (w_div_done) begin
            apu_result_o = w_div_quot;
            apu_rflags_o = w_div_flags;
        end
    end

    assign active_o = w_any_valid | w_div_busy;

    // The grant rules keep the pipeline tail and divider completion apart.
    a_no_double_return: assert property (
        @(posedge clk_i) disable iff (rst_i) !(w_tail.valid && w_div_done)
    );

endmodule

// File: tb/tb_cv32e40p_apu_resp.sv
// Directed bench for the APU responder. Inputs change and outputs are
// sampled on the falling edge, so each negedge marks one cycle.
module tb_cv32e40p_apu_resp;
    import cv32e40p_apu_resp_pkg::*;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             apu_req_i;
    logic             apu_gnt_o;
    logic [3:0]       apu_op_i;
    logic [1:0][31:0] apu_operands_i;
    logic             apu_rvalid_o;
    logic [31:0]      apu_result_o;
    logic [1:0]       apu_rflags_o;
    logic             active_o;

    int total = 0;
    int bad   = 0;

    cv32e40p_apu_resp #(
        .PIPE_DEPTH (3),
        .DIV_ENABLE (1'b1)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .apu_req_i      (apu_req_i),
        .apu_gnt_o      (apu_gnt_o),
        .apu_op_i       (apu_op_i),
        .apu_operands_i (apu_operands_i),
        .apu_rvalid_o   (apu_rvalid_o),
        .apu_result_o   (apu_result_o),
        .apu_rflags_o   (apu_rflags_o),
        .active_o       (active_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic req, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        apu_req_i         = req;
        apu_op_i          = op;
        apu_operands_i[0] = a;
        apu_operands_i[1] = b;
    endtask

    // ADD 5+7 held for one cycle: grant now, result next cycle, idle after.
    task automatic add_scenario();
        @(negedge clk_i);
        drive(1'b1, OP_ADD, 32'd5, 32'd7);
        #1;
        check("add_gnt", 32'(apu_gnt_o), 32'd1);
        check("add_rvalid_early", 32'(apu_rvalid_o), 32'd0);
        @(negedge clk_i);
        drive(1'b0, OP_ADD, 32'd0, 32'd0);
        #1;
        check("add_rvalid", 32'(apu_rvalid_o), 32'd1);
        check("add_result", apu_result_o, 32'd12);
        check("add_flags", 32'(apu_rflags_o), 32'd0);
        check("add_active", 32'(active_o), 32'd1);
        @(negedge clk_i);
        #1;
        check("add_rvalid_after", 32'(apu_rvalid_o), 32'd0);
        check("add_result_after", apu_result_o, 32'd0);
        check("add_active_after", 32'(active_o), 32'd0);
    endtask

    // DIVU with optional ADD held pending through the whole divide.
    task automatic div_case(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_q, input logic [1:0] exp_f,
                            input bit hold_add);
        @(negedge clk_i);
        drive(1'b1, OP_DIVU, a, b);
        #1;
        check("div_gnt", 32'(apu_gnt_o), 32'd1);
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk_i);
            if (k == 1) drive(hold_add, OP_ADD, 32'd1, 32'd1);
            #1;
            check("div_block_gnt", 32'(apu_gnt_o), 32'd0);
            check("div_rvalid", 32'(apu_rvalid_o), 32'(k == 33));
            check("div_active", 32'(active_o), 32'd1);
            if (k == 33) begin
                check("div_result", apu_result_o, exp_q);
                check("div_flags", 32'(apu_rflags_o), 32'(exp_f));
            end
        end
        @(negedge clk_i);
        #1;
        check("div_next_gnt", 32'(apu_gnt_o), 32'(hold_add));
        check("div_rvalid_after", 32'(apu_rvalid_o), 32'd0);
        if (hold_add) begin
            @(negedge clk_i);
            drive(1'b0, OP_ADD, 32'd0, 32'd0);
            #1;
            check("div_held_add_rvalid", 32'(apu_rvalid_o), 32'd1);
            check("div_held_add_result", apu_result_o, 32'd2);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  t_op  [7];
        logic [31:0] t_a   [7];
        logic [31:0] t_b   [7];
        logic [31:0] t_exp [7];
        int          pulses;

        t_op[0] = OP_ADD;  t_a[0] = 32'hFFFF_FFFF; t_b[0] = 32'd2;          t_exp[0] = 32'd1;
        t_op[1] = OP_SUB;  t_a[1] = 32'd3;         t_b[1] = 32'd5;          t_exp[1] = 32'hFFFF_FFFE;
        t_op[2] = OP_AND;  t_a[2] = 32'hF0F0_F0F0; t_b[2] = 32'hFF00_FF00; t_exp[2] = 32'hF000_F000;
        t_op[3] = OP_OR;   t_a[3] = 32'hF0F0_F0F0; t_b[3] = 32'h0F0F_0000; t_exp[3] = 32'hFFFF_F0F0;
        t_op[4] = OP_XOR;  t_a[4] = 32'hAAAA_5555; t_b[4] = 32'hFFFF_0000; t_exp[4] = 32'h5555_5555;
        t_op[5] = OP_SLTU; t_a[5] = 32'd3;         t_b[5] = 32'd5;          t_exp[5] = 32'd1;
        t_op[6] = OP_SLTU; t_a[6] = 32'd5;         t_b[6] = 32'd3;          t_exp[6] = 32'd0;

        // Reset state, with a request pending to show grant is masked.
        rst_i = 1'b1;
        drive(1'b1, OP_ADD, 32'd1, 32'd2);
        #1;
        check("rst_gnt", 32'(apu_gnt_o), 32'd0);
        check("rst_rvalid", 32'(apu_rvalid_o), 32'd0);
        check("rst_active", 32'(active_o), 32'd0);
        check("rst_result", apu_result_o, 32'd0);
        check("rst_flags", 32'(apu_rflags_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        drive(1'b0, OP_ADD, 32'd0, 32'd0);

        add_scenario();

        // Back-to-back single-cycle ops: each granted, each answered next cycle.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_i);
            drive(1'b1, t_op[i], t_a[i], t_b[i]);
            #1;
            check("alu_gnt", 32'(apu_gnt_o), 32'd1);
            if (i > 0) begin
                check("alu_rvalid", 32'(apu_rvalid_o), 32'd1);
                check("alu_result", apu_result_o, t_exp[i-1]);
            end
        end
        @(negedge clk_i);
        drive(1'b0, OP_ADD, 32'd0, 32'd0);
        #1;
        check("alu_rvalid_last", 32'(apu_rvalid_o), 32'd1);
        check("alu_result_last", apu_result_o, t_exp[6]);

        // Illegal op 12.
        @(negedge clk_i);
        drive(1'b1, 4'd12, 32'd1, 32'd2);
        #1;
        check("ill_gnt", 32'(apu_gnt_o), 32'd1);
        @(negedge clk_i);
        drive(1'b0, OP_ADD, 32'd0, 32'd0);
        #1;
        check("ill_rvalid", 32'(apu_rvalid_o), 32'd1);
        check("ill_result", apu_result_o, 32'd0);
        check("ill_flags", 32'(apu_rflags_o), 32'd1);

        // MUL then MULHU of 0x10000 x 0x10000 back to back (t, t+1).
        @(negedge clk_i);
        drive(1'b1, OP_MUL, 32'h0001_0000, 32'h0001_0000);
        #1;
        check("mul_gnt", 32'(apu_gnt_o), 32'd1);
        @(negedge clk_i);
        drive(1'b1, OP_MULHU, 32'h0001_0000, 32'h0001_0000);
        #1;
        check("mulhu_gnt", 32'(apu_gnt_o), 32'd1);
        check("mul_rvalid_t1", 32'(apu_rvalid_o), 32'd0);
        @(negedge clk_i);
        drive(1'b0, OP_ADD, 32'd0, 32'd0);
        #1;
        check("mul_rvalid_t2", 32'(apu_rvalid_o), 32'd0);
        check("mul_active_t2", 32'(active_o), 32'd1);
        @(negedge clk_i);
        #1;
        check("mul_rvalid_t3", 32'(apu_rvalid_o), 32'd1);
        check("mul_result_t3", apu_result_o, 32'd0);
        @(negedge clk_i);
        #1;
        check("mulhu_rvalid_t4", 32'(apu_rvalid_o), 32'd1);
        check("mulhu_result_t4", apu_result_o, 32'd1);
        @(negedge clk_i);
        #1;
        check("mul_rvalid_t5", 32'(apu_rvalid_o), 32'd0);

        // Full-width product: 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001.
        @(negedge clk_i);
        drive(1'b1, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk_i);
        drive(1'b1, OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk_i);
        drive(1'b0, OP_ADD, 32'd0, 32'd0);
        @(negedge clk_i);
        #1;
        check("big_mulhu", apu_result_o, 32'hFFFF_FFFE);
        @(negedge clk_i);
        #1;
        check("big_mul", apu_result_o, 32'd1);

        // MUL at t, ADD requested from t+1: held off until the MUL is
        // returning at t+3, then returns at t+4 behind it.
        @(negedge clk_i);
        drive(1'b1, OP_MUL, 32'd6, 32'd7);
        #1;
        check("mo_mul_gnt", 32'(apu_gnt_o), 32'd1);
        @(negedge clk_i);
        drive(1'b1, OP_ADD, 32'd1, 32'd2);
        #1;
        check("mo_add_gnt_t1", 32'(apu_gnt_o), 32'd0);
        @(negedge clk_i);
        #1;
        check("mo_add_gnt_t2", 32'(apu_gnt_o), 32'd0);
        @(negedge clk_i);
        #1;
        check("mo_add_gnt_t3", 32'(apu_gnt_o), 32'd1);
        check("mo_mul_rvalid", 32'(apu_rvalid_o), 32'd1);
        check("mo_mul_result", apu_result_o, 32'd42);
        @(negedge clk_i);
        drive(1'b0, OP_ADD, 32'd0, 32'd0);
        #1;
        check("mo_add_rvalid", 32'(apu_rvalid_o), 32'd1);
        check("mo_add_result", apu_result_o, 32'd3);
        @(negedge clk_i);
        #1;
        check("mo_rvalid_after", 32'(apu_rvalid_o), 32'd0);

        // Divider: normal, divide-by-zero, maximal dividend.
        div_case(32'd100, 32'd7, 32'd14, 2'b00, 1'b1);
        div_case(32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 2'b10, 1'b0);
        div_case(32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 2'b00, 1'b0);

        // Reset asserted mid-divide at t+10.
        @(negedge clk_i);
        drive(1'b1, OP_DIVU, 32'd100, 32'd7);
        #1;
        check("rd_gnt", 32'(apu_gnt_o), 32'd1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk_i);
            if (k == 1) drive(1'b0, OP_ADD, 32'd0, 32'd0);
        end
        @(negedge clk_i);
        #1;
        check("rd_active_before", 32'(active_o), 32'd1);
        rst_i = 1'b1;
        drive(1'b1, OP_ADD, 32'd5, 32'd7);
        #1;
        check("rd_gnt_in_rst", 32'(apu_gnt_o), 32'd0);
        check("rd_rvalid_in_rst", 32'(apu_rvalid_o), 32'd0);
        check("rd_active_in_rst", 32'(active_o), 32'd0);
        check("rd_result_in_rst", apu_result_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(1'b0, OP_ADD, 32'd0, 32'd0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            #1;
            if (apu_rvalid_o) pulses++;
        end
        check("rd_no_stale_rvalid", 32'(pulses), 32'd0);
        add_scenario();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
